nvram_port_arbiter: RTL
=======================

Name: nvram_port_arbiter

Overview:
Shares the single-port high-score/settings NVRAM between the game CPU and the HPS ioctl path.
- HPS download (ioctl index 4) writes into the NVRAM.
- HPS upload reads from the NVRAM, with ioctl_wait used as back-pressure.
- The CPU has priority, but a deferral counter guarantees the HPS gets a slot.
- A dirty flag tells the framework the NVRAM needs saving.

It sits between the core's CPU bus decode, the NVRAM block RAM and the hps_io ioctl signals, all on clk_sys.

Parameters:
AW, 10, NVRAM address width (depth 2^AW bytes)
DEFER_MAX, 3, number of consecutive CPU wins while an HPS request is pending before the HPS is forced through

Ports:
clk_sys  in  1  system clock (40 MHz)
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request; level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; sampled at grant
cpu_addr  in  AW  CPU address
cpu_din  in  8  CPU write data
cpu_dout  out  8  CPU read data, valid while cpu_ack is high
cpu_ack  out  1  one-cycle completion pulse
cpu_stall  out  1  high while cpu_req is held off by a forced HPS slot
hps_wr  in  1  one-cycle write strobe (ioctl_wr & nvram index)
hps_rd  in  1  one-cycle read strobe (upload request)
hps_addr  in  AW  ioctl address; lower AW bits are used
hps_din  in  8  ioctl_dout
hps_dout  out  8  ioctl_din; valid from the cycle hps_wait falls, held until the next HPS read completes
hps_wait  out  1  ioctl_wait
hps_err  out  1  sticky: a strobe arrived while an HPS request was pending
dirty  out  1  NVRAM modified by the CPU since the last full upload
ram_addr  out  AW  NVRAM address (registered)
ram_din  out  8  NVRAM write data (registered)
ram_we  out  1  NVRAM write enable (registered)
ram_dout  in  8  NVRAM read data; one-cycle read latency

Behaviour:
- Reset (asynchronous, immediate) clears all outputs and state to 0:
  - ram_we=0, ram_addr=0, ram_din=0, cpu_ack=0, cpu_dout=0, cpu_stall=0;
  - hps_wait=0, hps_dout=0, hps_err=0, dirty=0;
  - state=IDLE, defer_cnt=0, hps_pend=0.
- Reset mid-access aborts the access. No write is issued after reset asserts, and a write already registered is dropped.
- HPS latch:
  - A hps_wr or hps_rd pulse while hps_pend=0 latches the request (type, address, data) and sets hps_pend.
  - hps_wait goes high the next cycle and stays high until the access completes.
  - If hps_wr and hps_rd arrive in the same cycle, the write wins and the read is dropped with hps_err set.
  - A pulse while hps_pend=1 is dropped and sets hps_err.
- States: IDLE, CPU_ACC, CPU_DATA, HPS_ACC, HPS_DATA.
- Transitions out of IDLE:
  - If hps_pend and (cpu_req=0 or defer_cnt==DEFER_MAX): go to HPS_ACC and clear defer_cnt. If cpu_req=1 in that case, cpu_stall=1 for that cycle.
  - Else if cpu_req: go to CPU_ACC. defer_cnt increments (saturating at DEFER_MAX) if hps_pend=1.
  - Else: stay in IDLE.
- CPU_ACC:
  - ram_addr/ram_din/ram_we are driven from the CPU fields for exactly one cycle.
  - A CPU write sets dirty.
  - Next state is CPU_DATA.
- CPU_DATA:
  - cpu_dout <= ram_dout and cpu_ack pulses for one cycle. For writes, cpu_dout is unchanged.
  - Next state is IDLE.
  - The CPU must drop cpu_req on the cycle after cpu_ack. A req still high re-arbitrates as a new access.
- HPS_ACC: ram_* are driven from the latched HPS fields for one cycle. Next state is HPS_DATA.
- HPS_DATA:
  - For reads, hps_dout <= ram_dout.
  - hps_pend and hps_wait clear on the following cycle edge, so hps_wait falls 1 cycle after HPS_DATA.
  - Next state is IDLE.
- ram_we is 0 in every state other than an *_ACC state carrying a write.
- Latency, counted from the request cycle in IDLE: CPU access is 3 cycles to cpu_ack. An uncontended HPS access holds hps_wait high for 3 cycles.
- dirty:
  - Cleared when an HPS read of address 2^AW-1 completes (end of upload).
  - If a CPU write and that completion occur in the same cycle, set wins.
  - HPS writes never set dirty.
- Address wrap: hps_addr above 2^AW-1 is truncated to its lower AW bits; no error is raised.

Test Plan:
- Idle CPU write: cpu_req=1, we=1, addr=0x005, din=0xA5 -> ram_we=1 for one cycle with ram_addr=0x005; cpu_ack 3 cycles after req; dirty=1.
- CPU read-back: read 0x005 -> cpu_ack with cpu_dout=0xA5; ram_we stays 0.
- HPS download: hps_wr pulse, addr=0x3FF, din=0x5A, CPU idle -> hps_wait high for exactly 3 cycles; RAM[0x3FF]=0x5A; dirty unchanged.
- Contention fairness: cpu_req held continuously, hps_rd pulse -> CPU wins 3 times (DEFER_MAX); 4th arbitration goes to HPS with cpu_stall=1 for one cycle; hps_dout = RAM contents.
- Full upload: hps_rd over addresses 0..0x3FF, each waiting for hps_wait low -> dirty clears after the 0x3FF completion; a second hps_rd pulse issued while hps_wait=1 sets hps_err=1.
- Async reset: assert reset during HPS_ACC of a write -> ram_we, hps_wait and dirty are 0 immediately (before any clock edge); RAM is not written.

Source files
------------

// File: rtl/nvram_port_arbiter.sv
// Arbiter sharing the single-port settings NVRAM between the game CPU and the HPS ioctl path.
// The CPU has priority; a deferral counter forces a pending HPS access through.
module nvram_port_arbiter #(
  parameter int unsigned AW        = 10,
  parameter int unsigned DEFER_MAX = 3
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          hps_wr,
  input  logic          hps_rd,
  input  logic [AW-1:0] hps_addr,
  input  logic [7:0]    hps_din,
  output logic [7:0]    hps_dout,
  output logic          hps_wait,
  output logic          hps_err,
  output logic          dirty,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout
);

  localparam int unsigned DW = (DEFER_MAX > 0) ? $clog2(DEFER_MAX + 1) : 1;
  localparam logic [DW-1:0] DeferMax = DW'(DEFER_MAX);

  typedef enum logic [2:0] {StIdle, StCpuAcc, StCpuData, StHpsAcc, StHpsData} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] defer_q, defer_d;
  logic          hps_pend_q, hps_pend_d;
  logic          hps_we_q, hps_we_d;
  logic [AW-1:0] hps_addr_q, hps_addr_d;
  logic [7:0]    hps_din_q, hps_din_d;
  logic          op_we_q, op_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]    ram_din_q, ram_din_d;
  logic          ram_we_q, ram_we_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [7:0]    hps_dout_q, hps_dout_d;
  logic          hps_err_q, hps_err_d;
  logic          dirty_q, dirty_d;
  logic          dirty_set, dirty_clr;

  always_comb begin
    state_d    = state_q;
    defer_d    = defer_q;
    hps_pend_d = hps_pend_q;
    hps_we_d   = hps_we_q;
    hps_addr_d = hps_addr_q;
    hps_din_d  = hps_din_q;
    op_we_d    = op_we_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    cpu_dout_d = cpu_dout_q;
    cpu_ack_d  = 1'b0;
    hps_dout_d = hps_dout_q;
    hps_err_d  = hps_err_q;
    dirty_set  = 1'b0;
    dirty_clr  = 1'b0;
    cpu_stall  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The ack cycle is a turnaround: the CPU is still holding req for the finished access.
        if (!cpu_ack_q) begin
          if (hps_pend_q && (!cpu_req || defer_q == DeferMax)) begin
            state_d    = StHpsAcc;
            defer_d    = '0;
            cpu_stall  = cpu_req;
            op_we_d    = hps_we_q;
            ram_addr_d = hps_addr_q;
            ram_din_d  = hps_din_q;
            ram_we_d   = hps_we_q;
          end else if (cpu_req) begin
            state_d = StCpuAcc;
            if (hps_pend_q && defer_q != DeferMax) defer_d = defer_q + DW'(1);
            op_we_d    = cpu_we;
            ram_addr_d = cpu_addr;
            ram_din_d  = cpu_din;
            ram_we_d   = cpu_we;
          end
        end
      end
      StCpuAcc: begin
        state_d   = StCpuData;
        dirty_set = op_we_q;
      end
      StCpuData: begin
        state_d   = StIdle;
        cpu_ack_d = 1'b1;
        if (!op_we_q) cpu_dout_d = ram_dout;
      end
      StHpsAcc: state_d = StHpsData;
      StHpsData: begin
        state_d    = StIdle;
        hps_pend_d = 1'b0;
        if (!op_we_q) begin
          hps_dout_d = ram_dout;
          dirty_clr  = &ram_addr_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // Strobes are single-cycle, so anything that cannot be latched is lost and flagged.
    if (hps_wr || hps_rd) begin
      if (hps_pend_q) begin
        hps_err_d = 1'b1;
      end else begin
        hps_pend_d = 1'b1;
        hps_we_d   = hps_wr;
        hps_addr_d = hps_addr;
        hps_din_d  = hps_din;
        if (hps_wr && hps_rd) hps_err_d = 1'b1;
      end
    end

    dirty_d = dirty_q;
    if (dirty_clr) dirty_d = 1'b0;
    if (dirty_set) dirty_d = 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      defer_q    <= '0;
      hps_pend_q <= 1'b0;
      hps_we_q   <= 1'b0;
      hps_addr_q <= '0;
      hps_din_q  <= '0;
      op_we_q    <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      cpu_dout_q <= '0;
      cpu_ack_q  <= 1'b0;
      hps_dout_q <= '0;
      hps_err_q  <= 1'b0;
      dirty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      defer_q    <= defer_d;
      hps_pend_q <= hps_pend_d;
      hps_we_q   <= hps_we_d;
      hps_addr_q <= hps_addr_d;
      hps_din_q  <= hps_din_d;
      op_we_q    <= op_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      cpu_dout_q <= cpu_dout_d;
      cpu_ack_q  <= cpu_ack_d;
      hps_dout_q <= hps_dout_d;
      hps_err_q  <= hps_err_d;
      dirty_q    <= dirty_d;
    end
  end

  assign cpu_dout = cpu_dout_q;
  assign cpu_ack  = cpu_ack_q;
  assign hps_dout = hps_dout_q;
  assign hps_wait = hps_pend_q;
  assign hps_err  = hps_err_q;
  assign dirty    = dirty_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;

endmodule
